uart_rx: RTL and testbench

//  Memory-mapped UART receiver: the receive-side companion of the transmit-only uart on the CPU data bus.

---
 rtl/uart_rx.sv | 142 ++++++++++++++
 tb/tb_uart_rx.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a 2-flop input synchroniser, a mid-bit sampling FSM,
// a small fall-through byte FIFO and sticky overrun / framing-error flags.
module uart_rx #(
  parameter int CLKDIV  = 434,
  parameter int FIFO_AW = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       rd,
  input  logic       clr_err,
  output logic [7:0] rdata,
  output logic       valid,
  output logic       full,
  output logic       overrun,
  output logic       frame_err
);

  localparam int TW    = $clog2(CLKDIV);
  localparam int DEPTH = 1 << FIFO_AW;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t             state;
  logic [TW-1:0]      timer;
  logic [2:0]         idx;
  logic [7:0]         shreg;
  logic               rx_meta;
  logic               rxs;
  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW:0]   wp;
  logic [FIFO_AW:0]   rp;
  logic               expired;
  logic               push;
  logic               ferr_set;
  logic               empty;
  logic               pop;
  logic               accept;
  logic               drop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  always_comb begin
    expired  = (timer == '0);
    push     = (state == S_STOP) && expired && rxs;
    ferr_set = (state == S_STOP) && expired && !rxs;
    empty    = (wp == rp);
    full     = (wp[FIFO_AW] != rp[FIFO_AW]) &&
               (wp[FIFO_AW-1:0] == rp[FIFO_AW-1:0]);
    valid    = !empty;
    pop      = rd && !empty;
    // A pop in the same cycle frees the slot the incoming byte needs.
    accept   = push && (!full || pop);
    drop     = push && full && !pop;
    rdata    = empty ? '0 : mem[rp[FIFO_AW-1:0]];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      timer <= '0;
      idx   <= '0;
      shreg <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!rxs) begin
            state <= S_START;
            timer <= TW'(CLKDIV / 2 - 1);
          end
        end
        S_START: begin
          if (expired) begin
            if (rxs) begin
              state <= S_IDLE;
            end else begin
              state <= S_DATA;
              idx   <= '0;
              timer <= TW'(CLKDIV - 1);
            end
          end else begin
            timer <= timer - 1'b1;
          end
        end
        S_DATA: begin
          if (expired) begin
            shreg <= {rxs, shreg[7:1]};
            idx   <= idx + 1'b1;
            timer <= TW'(CLKDIV - 1);
            if (idx == 3'd7) state <= S_STOP;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        S_STOP: begin
          if (expired) begin
            state <= rxs ? S_IDLE : S_BREAK;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        S_BREAK: begin
          if (rxs) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp        <= '0;
      rp        <= '0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (pop)    rp <= rp + 1'b1;
      if (accept) wp <= wp + 1'b1;
      overrun   <= drop     | (overrun   & ~clr_err);
      frame_err <= ferr_set | (frame_err & ~clr_err);
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem[wp[FIFO_AW-1:0]] <= shreg;
  end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: a queue-based model predicts FIFO contents and flags from the
// frames sent, checked every cycle, plus literal spot checks per scenario.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic       rd = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] rdata;
  logic       valid;
  logic       full;
  logic       overrun;
  logic       frame_err;

  uart_rx #(.CLKDIV(16), .FIFO_AW(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .rd        (rd),
    .clr_err   (clr_err),
    .rdata     (rdata),
    .valid     (valid),
    .full      (full),
    .overrun   (overrun),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  int ntests = 0;
  int nfail  = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a frame whose start bit is driven after edge E0 resolves at edge E0+155
  // (2 sync + 8 half-bit + 8*16 data + 16 stop + 1).
  typedef struct {
    int unsigned cyc;
    logic [7:0]  b;
    bit          good;
  } ev_t;

  ev_t         sched[$];
  logic [7:0]  mq[$];
  bit          m_ov = 1'b0;
  bit          m_fe = 1'b0;
  int unsigned cyc = 0;

  always @(posedge clk or posedge reset) begin : model
    bit         do_pop;
    bit         got;
    bit         good;
    bit         ov_set;
    bit         fe_set;
    logic [7:0] b;
    if (reset) begin
      mq.delete();
      sched.delete();
      m_ov = 1'b0;
      m_fe = 1'b0;
    end else begin
      cyc++;
      do_pop = rd && (mq.size() > 0);
      got = 1'b0; good = 1'b0; b = 8'h00; ov_set = 1'b0; fe_set = 1'b0;
      foreach (sched[i]) begin
        if (sched[i].cyc == cyc) begin
          got = 1'b1; good = sched[i].good; b = sched[i].b;
        end
      end
      if (do_pop) void'(mq.pop_front());
      if (got) begin
        if (!good) fe_set = 1'b1;
        else if (mq.size() < 4) mq.push_back(b);
        else ov_set = 1'b1;
      end
      m_ov = ov_set | (m_ov & !clr_err);
      m_fe = fe_set | (m_fe & !clr_err);
    end
  end

  always @(negedge clk) begin
    check("cyc_valid",     {7'b0, valid},     {7'b0, mq.size() > 0});
    check("cyc_full",      {7'b0, full},      {7'b0, mq.size() == 4});
    check("cyc_rdata",     rdata,             (mq.size() > 0) ? mq[0] : 8'h00);
    check("cyc_overrun",   {7'b0, overrun},   {7'b0, m_ov});
    check("cyc_frame_err", {7'b0, frame_err}, {7'b0, m_fe});
  end

  // abort_at >= 0 asserts reset at that bit-cycle of the frame and returns with reset high.
  task automatic send(input logic [7:0] b, input bit stop_ok, input int hold_low,
                      input bit rd_push, input int abort_at);
    logic [9:0]  frame;
    int unsigned e0;
    frame = {stop_ok, b, 1'b0};
    @(posedge clk); #1;
    e0 = cyc;
    sched.push_back('{e0 + 155, b, stop_ok});
    for (int k = 0; k < 160; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      rx = frame[k / 16];
      rd = rd_push && (k == 154);
      if (k == abort_at) begin
        #1 reset = 1'b1;
        rx = 1'b1;
        rd = 1'b0;
        return;
      end
    end
    @(posedge clk); #1;
    rd = 1'b0;
    repeat (hold_low) @(posedge clk);
    #1 rx = 1'b1;
    repeat (6) @(posedge clk);
  endtask

  task automatic pop1();
    @(posedge clk); #1 rd = 1'b1;
    @(posedge clk); #1 rd = 1'b0;
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1 clr_err = 1'b1;
    @(posedge clk); #1 clr_err = 1'b0;
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  initial begin
    logic [7:0] exp_rd [4];
    repeat (3) @(posedge clk);
    settle();
    check("rst_valid", {7'b0, valid}, 8'h00);
    check("rst_rdata", rdata, 8'h00);
    check("rst_flags", {6'b0, overrun, frame_err}, 8'h00);
    @(posedge clk); #1 reset = 1'b0;
    repeat (4) @(posedge clk);

    // 1: basic frame
    send(8'h55, 1'b1, 0, 1'b0, -1);
    settle();
    check("s1_valid", {7'b0, valid}, 8'h01);
    check("s1_rdata", rdata, 8'h55);
    pop1();
    settle();
    check("s1_pop_valid", {7'b0, valid}, 8'h00);
    check("s1_pop_rdata", rdata, 8'h00);

    // 2: short glitch rejected
    @(posedge clk); #1 rx = 1'b0;
    repeat (4) @(posedge clk);
    #1 rx = 1'b1;
    repeat (30) @(posedge clk);
    settle();
    check("s2_glitch_valid", {7'b0, valid}, 8'h00);
    check("s2_glitch_ferr", {7'b0, frame_err}, 8'h00);
    send(8'h3C, 1'b1, 0, 1'b0, -1);
    settle();
    check("s2_rdata", rdata, 8'h3C);
    pop1();

    // 3: bad stop bit followed by a held-low line
    send(8'hA5, 1'b0, 40, 1'b0, -1);
    repeat (20) @(posedge clk);
    settle();
    check("s3_ferr", {7'b0, frame_err}, 8'h01);
    check("s3_valid", {7'b0, valid}, 8'h00);
    pulse_clr();
    settle();
    check("s3_ferr_clr", {7'b0, frame_err}, 8'h00);
    send(8'h81, 1'b1, 0, 1'b0, -1);
    settle();
    check("s3_rdata", rdata, 8'h81);
    pop1();

    // 4: overflow
    for (int i = 1; i <= 4; i++) send(8'(i), 1'b1, 0, 1'b0, -1);
    settle();
    check("s4_full", {7'b0, full}, 8'h01);
    check("s4_no_ovr", {7'b0, overrun}, 8'h00);
    send(8'h05, 1'b1, 0, 1'b0, -1);
    settle();
    check("s4_overrun", {7'b0, overrun}, 8'h01);
    for (int i = 1; i <= 4; i++) begin
      settle();
      check("s4_read", rdata, 8'(i));
      pop1();
    end
    settle();
    check("s4_empty", {7'b0, valid}, 8'h00);

    // 5: push and pop on the same edge while full
    pulse_clr();
    for (int i = 1; i <= 4; i++) send(8'(i), 1'b1, 0, 1'b0, -1);
    send(8'h06, 1'b1, 0, 1'b1, -1);
    settle();
    check("s5_no_ovr", {7'b0, overrun}, 8'h00);
    check("s5_full", {7'b0, full}, 8'h01);
    exp_rd = '{8'h02, 8'h03, 8'h04, 8'h06};
    for (int i = 0; i < 4; i++) begin
      settle();
      check("s5_read", rdata, exp_rd[i]);
      pop1();
    end

    // 6: reset mid-frame, with a byte already waiting
    send(8'h11, 1'b1, 0, 1'b0, -1);
    send(8'hF0, 1'b1, 0, 1'b0, 70);
    settle();
    check("s6_rst_valid", {7'b0, valid}, 8'h00);
    check("s6_rst_rdata", rdata, 8'h00);
    check("s6_rst_full", {7'b0, full}, 8'h00);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (4) @(posedge clk);
    send(8'h3C, 1'b1, 0, 1'b0, -1);
    settle();
    check("s6_rdata", rdata, 8'h3C);
    check("s6_flags", {6'b0, overrun, frame_err}, 8'h00);
    pop1();
    repeat (4) @(posedge clk);
    settle();

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
